// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: one write slot per result producer, round-robin
// grant of up to two slots per cycle onto the two write ports, never the same register twice.
module rf_write_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*N-1:0]    req_data,
    output logic [AW-1:0]        write_address,
    output logic [N-1:0]         write_data,
    output logic                 write_enable,
    output logic [AW-1:0]        write_address_2,
    output logic [N-1:0]         write_data_2,
    output logic                 write_enable_2,
    output logic [(2**AW)-1:0]   pending_mask,
    output logic                 idle
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] full_q;
    logic [AW-1:0]   addr_q [NREQ];
    logic [N-1:0]    data_q [NREQ];
    logic [PW-1:0]   rr_q, rr_d;
    logic [AW-1:0]   wa_q, wa2_q;
    logic [N-1:0]    wd_q, wd2_q;
    logic            we_q, we2_q;

    logic            g1_vld, g2_vld;
    logic [PW-1:0]   g1, g2, last_g;
    logic [PW:0]     scan_sum, rr_sum;
    logic [PW-1:0]   scan_idx;
    logic [NREQ-1:0] grant, accept;

    // Round-robin scan from rr_q: first full slot, then next full slot with a different address
    always_comb begin
        g1_vld   = 1'b0;
        g2_vld   = 1'b0;
        g1       = '0;
        g2       = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            scan_sum = (PW+1)'(rr_q) + (PW+1)'(j);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (full_q[scan_idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1     = scan_idx;
                end else if (!g2_vld && (addr_q[scan_idx] != addr_q[g1])) begin
                    g2_vld = 1'b1;
                    g2     = scan_idx;
                end
            end
        end
        grant = '0;
        if (g1_vld) grant[g1] = 1'b1;
        if (g2_vld) grant[g2] = 1'b1;
    end

    // Pointer advances past the last granted slot
    always_comb begin
        last_g = g2_vld ? g2 : g1;
        rr_sum = (PW+1)'(last_g) + (PW+1)'(1);
        if (rr_sum >= (PW+1)'(NREQ)) begin
            rr_sum = '0;
        end
        rr_d = rr_q;
        if (g1_vld) rr_d = rr_sum[PW-1:0];
    end

    // Ready depends only on registered state; held low while reset is asserted
    assign req_ready = {NREQ{rst_n}} & (~full_q | grant);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            rr_q   <= '0;
            wa_q   <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            wa2_q  <= '0;
            wd2_q  <= '0;
            we2_q  <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    full_q[i] <= 1'b1;
                    addr_q[i] <= req_addr[i*AW +: AW];
                    data_q[i] <= req_data[i*N +: N];
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            if (g1_vld) begin
                wa_q <= addr_q[g1];
                wd_q <= data_q[g1];
            end
            if (g2_vld) begin
                wa2_q <= addr_q[g2];
                wd2_q <= data_q[g2];
            end
            we_q  <= g1_vld;
            we2_q <= g2_vld;
            rr_q  <= rr_d;
        end
    end

    // Hazard mask: every register with a write queued in a slot or on a port
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (full_q[i]) pending_mask[addr_q[i]] = 1'b1;
        end
        if (we_q)  pending_mask[wa_q]  = 1'b1;
        if (we2_q) pending_mask[wa2_q] = 1'b1;
    end

    assign idle            = ~(|full_q) & ~we_q & ~we2_q;
    assign write_address   = wa_q;
    assign write_data      = wd_q;
    assign write_enable    = we_q;
    assign write_address_2 = wa2_q;
    assign write_data_2    = wd2_q;
    assign write_enable_2  = we2_q;

endmodule
